// File: rtl/piso_serializer.sv
// piso_serializer
//   Parallel-in, serial-out register. A WIDTH-bit word is accepted over a
//   valid/ready handshake and then shifted out one bit per accepted beat on a
//   serial valid/ready interface. Words may be streamed back-to-back with no
//   bubble: the next word loads on the same edge that transfers the last bit.
//
// Parameters
//   WIDTH      word width in bits (2..32)
//   MSB_FIRST  0: bit 0 leaves first, 1: bit WIDTH-1 leaves first
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous, active-high reset
//   in_data    parallel word to serialize
//   in_valid   in_data is valid
//   in_ready   a word can be accepted this cycle (combinational from out_ready)
//   out        current serial bit
//   out_valid  out holds a valid bit
//   out_last   current bit is the final bit of the word
//   out_ready  consumer accepts the current bit this cycle
//   busy       a word is held
module piso_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             out,
  output logic             out_valid,
  output logic             out_last,
  input  logic             out_ready,
  output logic             busy
);

  localparam int unsigned CW = $clog2(WIDTH);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] shreg, shreg_nx;
  logic [CW-1:0]    cnt;
  logic             load, shift;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      shreg <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      if (load) begin
        shreg <= shreg_nx;
        cnt   <= CW'(WIDTH - 1);
      end else if (shift) begin
        shreg <= shreg_nx;
        cnt   <= cnt - CW'(1);
      end
    end
  end

  // Each bit is a load cell: its source is either the parallel word or its
  // neighbour one step further from the output end; the far end fills with 0.
  always_comb begin
    if (load) begin
      shreg_nx = in_data;
    end else if (MSB_FIRST) begin
      shreg_nx = {shreg[WIDTH-2:0], 1'b0};
    end else begin
      shreg_nx = {1'b0, shreg[WIDTH-1:1]};
    end
  end

  always_comb begin
    state_nx  = state;
    in_ready  = 1'b0;
    out       = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    busy      = 1'b0;
    load      = 1'b0;
    shift     = 1'b0;

    unique case (state)
      IDLE: begin
        in_ready = !reset;
        if (in_valid && in_ready) begin
          load     = 1'b1;
          state_nx = SHIFT;
        end
      end

      SHIFT: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        out       = MSB_FIRST ? shreg[WIDTH-1] : shreg[0];
        out_last  = (cnt == '0);
        shift     = out_ready;
        // Readiness for the next word rides on the last-bit transfer so a
        // continuous stream sees no idle cycle between words.
        in_ready  = !reset && out_last && out_ready;
        if (shift && out_last) begin
          if (in_valid) begin
            load = 1'b1;
          end else begin
            state_nx = IDLE;
          end
        end
      end

      default: state_nx = IDLE;
    endcase
  end

endmodule
